// File: rtl/dct_row_butterfly_if.sv
// Handshake bundle for dct_row_butterfly: pixel input stream and (odd, even) pair output stream.
// The slave modport is the butterfly's view; the master modport is the producer/consumer side.
interface dct_row_butterfly_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pix;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] e;
    logic [1:0] out_idx;
    logic [2:0] row_idx;
    logic       blk_last;

    modport slave (
        input  in_valid, in_pix, out_ready,
        output in_ready, out_valid, a, e, out_idx, row_idx, blk_last
    );

    modport master (
        output in_valid, in_pix, out_ready,
        input  in_ready, out_valid, a, e, out_idx, row_idx, blk_last
    );
endinterface

// File: rtl/dct_row_butterfly.sv
// Row-input butterfly for the 8x8 DCT: buffers an 8-sample row, then emits four
// (odd, even) pairs a = (x[i]-x[7-i])>>>1, e = (x[i]+x[7-i])>>>1, i = 0..3.
// Optional macro DCT_LEVEL_SHIFT_EN: treat in_pix as unsigned 0..255 and subtract 128
// before storage; otherwise in_pix is a signed sample stored unchanged.
module dct_row_butterfly #(
    parameter int unsigned ROWS_PER_BLK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dct_row_butterfly_if.slave   bus
);

    typedef enum logic [0:0] {StFill, StEmit} state_e;

    localparam logic [2:0] LastRow = 3'(ROWS_PER_BLK - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  out_idx_q, out_idx_d;
    logic [2:0]  row_idx_q, row_idx_d;
    logic [7:0]  buf_q [8];
    logic [7:0]  buf_d [8];
    logic [7:0]  a_q, a_d;
    logic [7:0]  e_q, e_d;
    logic        blk_last_q, blk_last_d;

    logic [7:0]  pix_x;
    logic        in_fire, out_fire;
    logic [2:0]  lo_idx, hi_idx;
    logic [8:0]  x_lo, x_hi, sum, diff;

    // Convert the incoming pixel to a signed sample.
    always_comb begin
`ifdef DCT_LEVEL_SHIFT_EN
        pix_x = {~bus.in_pix[7], bus.in_pix[6:0]};
`else
        pix_x = bus.in_pix;
`endif
    end

    assign bus.in_ready  = (state_q == StFill) && !rst;
    assign bus.out_valid = (state_q == StEmit);
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    // Next-state: fill the row buffer, then step through the four output pairs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_idx_d = out_idx_q;
        row_idx_d = row_idx_q;
        buf_d     = buf_q;
        unique case (state_q)
            StFill: begin
                if (in_fire) begin
                    buf_d[cnt_q] = pix_x;
                    cnt_d        = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                if (out_fire) begin
                    if (out_idx_q == 2'd3) begin
                        out_idx_d = 2'd0;
                        row_idx_d = (row_idx_q == LastRow) ? 3'd0 : row_idx_q + 3'd1;
                        state_d   = StFill;
                    end else begin
                        out_idx_d = out_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Butterfly on the next buffer/index so pair 0 is ready the cycle after the 8th pixel.
    always_comb begin
        lo_idx     = {1'b0, out_idx_d};
        hi_idx     = 3'd7 - lo_idx;
        x_lo       = {buf_d[lo_idx][7], buf_d[lo_idx]};
        x_hi       = {buf_d[hi_idx][7], buf_d[hi_idx]};
        sum        = x_lo + x_hi;
        diff       = x_lo - x_hi;
        e_d        = sum[8:1];
        a_d        = diff[8:1];
        blk_last_d = (state_d == StEmit) && (out_idx_d == 2'd3) && (row_idx_d == LastRow);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFill;
            cnt_q      <= 3'd0;
            out_idx_q  <= 2'd0;
            row_idx_q  <= 3'd0;
            a_q        <= 8'd0;
            e_q        <= 8'd0;
            blk_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_idx_q  <= out_idx_d;
            row_idx_q  <= row_idx_d;
            a_q        <= a_d;
            e_q        <= e_d;
            blk_last_q <= blk_last_d;
        end
    end

    // Sample buffer needs no reset; it is always refilled before use.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign bus.a        = a_q;
    assign bus.e        = e_q;
    assign bus.out_idx  = out_idx_q;
    assign bus.row_idx  = row_idx_q;
    assign bus.blk_last = blk_last_q;

endmodule
